// File: rtl/axi4s_deframer_if.sv
// Bundles both streams of the deframer: the stuffed byte input (rx_byte_*)
// and the decoded payload output (rx_frame_*).
//
// Handshake rule for both streams: a beat transfers on a rising aclk edge
// where tvalid & tready are both high. Once tvalid is raised, tvalid and the
// payload signals hold steady until that transfer happens. tvalid never
// depends combinationally on tready.
//
// modport master: the deframer side (sinks rx_byte, sources rx_frame).
// modport slave : the environment side (sources rx_byte, sinks rx_frame).
interface axi4s_deframer_if;
  logic       rx_byte_tvalid;
  logic       rx_byte_tready;
  logic [7:0] rx_byte_tdata;
  logic       rx_frame_tvalid;
  logic       rx_frame_tready;
  logic [7:0] rx_frame_tdata;
  logic       rx_frame_tlast;
  logic       rx_frame_tuser;

  modport master (
    input  rx_byte_tvalid,
    output rx_byte_tready,
    input  rx_byte_tdata,
    output rx_frame_tvalid,
    input  rx_frame_tready,
    output rx_frame_tdata,
    output rx_frame_tlast,
    output rx_frame_tuser
  );

  modport slave (
    output rx_byte_tvalid,
    input  rx_byte_tready,
    output rx_byte_tdata,
    input  rx_frame_tvalid,
    output rx_frame_tready,
    input  rx_frame_tdata,
    input  rx_frame_tlast,
    input  rx_frame_tuser
  );
endinterface

// File: rtl/axi4s_deframer.sv
// Byte-stuffed stream deframer. Hunts for START, un-escapes payload bytes,
// and emits each payload byte one event late through a hold register so
// tlast (and tuser for aborted/oversized frames) rides on the final byte.
module axi4s_deframer #(
  parameter int START_BYTE  = 125,
  parameter int STOP_BYTE   = 126,
  parameter int ESCAPE_BYTE = 127,
  parameter int MAX_LEN     = 1024
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi4s_deframer_if.master bus,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
  localparam logic [7:0] START_B  = 8'(START_BYTE);
  localparam logic [7:0] STOP_B   = 8'(STOP_BYTE);
  localparam logic [7:0] ESCAPE_B = 8'(ESCAPE_BYTE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_ESCAPE  = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            hold_valid;
  logic [7:0]      hold_data;
  logic [CW-1:0]   count;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_last;
  logic            out_user;

  logic            byte_ready;
  logic            accept;
  logic [7:0]      in_byte;
  logic            is_start;
  logic            is_stop;
  logic            is_escape;
  logic            cnt_full;

  // Per-byte actions decoded from state and the accepted byte.
  logic            payload;
  logic            emit;
  logic            emit_last;
  logic            emit_user;
  logic            hold_load;
  logic            hold_clr;
  logic            cnt_clr;

  // The input stalls only while a loaded output beat is waiting downstream.
  assign byte_ready = ~out_valid | bus.rx_frame_tready;
  assign accept     = bus.rx_byte_tvalid & byte_ready;
  assign in_byte    = bus.rx_byte_tdata;
  assign is_start   = (in_byte == START_B);
  assign is_stop    = (in_byte == STOP_B);
  assign is_escape  = (in_byte == ESCAPE_B);
  assign cnt_full   = (count == MAX_CNT);

  assign bus.rx_byte_tready  = byte_ready;
  assign bus.rx_frame_tvalid = out_valid;
  assign bus.rx_frame_tdata  = out_data;
  assign bus.rx_frame_tlast  = out_last;
  assign bus.rx_frame_tuser  = out_user;
  assign dbg_state           = state;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; only an accepted byte moves the FSM.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_IDLE:    if (is_start) state_nxt = S_DATA;
        S_DATA: begin
          if (is_escape)     state_nxt = S_ESCAPE;
          else if (is_stop)  state_nxt = S_IDLE;
          else if (is_start) state_nxt = S_DATA;
          else if (cnt_full) state_nxt = S_DISCARD;
        end
        S_ESCAPE:  state_nxt = cnt_full ? S_DISCARD : S_DATA;
        S_DISCARD: begin
          if (is_stop)       state_nxt = S_IDLE;
          else if (is_start) state_nxt = S_DATA;
        end
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Action decode: what happens to the hold register, counter and output.
  always_comb begin
    payload   = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_user = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    cnt_clr   = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            hold_clr = 1'b1;
            cnt_clr  = 1'b1;
          end
        end
        S_DATA: begin
          if (is_escape) begin
            payload = 1'b0;
          end else if (is_stop) begin
            emit      = hold_valid;
            emit_last = 1'b1;
            hold_clr  = 1'b1;
          end else if (is_start) begin
            emit      = hold_valid;
            emit_last = 1'b1;
            emit_user = 1'b1;
            hold_clr  = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            payload = 1'b1;
          end
        end
        S_ESCAPE: payload = 1'b1;
        S_DISCARD: begin
          if (is_start) begin
            hold_clr = 1'b1;
            cnt_clr  = 1'b1;
          end
        end
        default: payload = 1'b0;
      endcase
    end
    // A payload byte beyond MAX_LEN closes the frame as truncated.
    if (payload) begin
      emit = hold_valid;
      if (cnt_full) begin
        emit_last = 1'b1;
        emit_user = 1'b1;
        hold_clr  = 1'b1;
      end else begin
        hold_load = 1'b1;
      end
    end
  end

  // Hold register, payload counter and registered output beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_last   <= 1'b0;
      out_user   <= 1'b0;
    end else begin
      if (hold_clr) begin
        hold_valid <= 1'b0;
      end else if (hold_load) begin
        hold_valid <= 1'b1;
        hold_data  <= in_byte;
      end
      if (cnt_clr)        count <= '0;
      else if (hold_load) count <= count + CW'(1);
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= hold_data;
        out_last  <= emit_last;
        out_user  <= emit_user;
      end else if (bus.rx_frame_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
